// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, one-hot receiver state encoding and a
// constant clog2 helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_START   = 6'b000010,
    ST_DATA    = 6'b000100,
    ST_PARITY  = 6'b001000,
    ST_STOP    = 6'b010000,
    ST_WAIT_HI = 6'b100000
  } rx_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchroniser for asynchronous single-bit inputs (N >= 2); every flop
// resets to RST_V so an idle-high line never looks like an edge out of reset.
module uart_rx_sync #(
  parameter int   N     = 2,
  parameter logic RST_V = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {N{RST_V}};
    else        sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority voting, parity, framing and
// break detection; the frame ends at mid-stop-bit so frames may run back to back.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int PARITY = PAR_NONE,
  parameter int STOP_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smp_tick_i,
  input  logic              rxd_i,
  output logic [DATA_W-1:0] rxd_data_o,
  output logic              rxd_flag_o,
  output logic              par_err_o,
  output logic              frm_err_o,
  output logic              brk_o
);

  localparam int CNT_W = clog2(OVS);
  localparam int IDX_W = clog2(DATA_W);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVS - 1);
  localparam logic [CNT_W-1:0] CNT_S0    = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_S1    = CNT_W'(OVS / 2);
  localparam logic [CNT_W-1:0] CNT_S2    = CNT_W'(OVS / 2 + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_W - 1);

  logic              rxd_s;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              stop_err_q, stop_err_d;
  logic [1:0]        smp_q, smp_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              flag_q, flag_d;
  logic              par_err_q, par_err_d;
  logic              frm_err_q, frm_err_d;
  logic              brk_q, brk_d;

  logic bit_end, maj_ev, maj, last_stop, done, par_calc;

  uart_rx_sync #(.N(2), .RST_V(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rxd_i),
    .q_o  (rxd_s)
  );

  assign bit_end   = smp_tick_i && (cnt_q == CNT_LAST);
  assign maj_ev    = smp_tick_i && (cnt_q == CNT_S2);
  assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s) | (smp_q[1] & rxd_s);
  assign last_stop = (state_q == ST_STOP) && (idx_q == STOP_LAST);
  assign done      = maj_ev && last_stop;
  assign par_calc  = (PARITY == PAR_EVEN) ?  (^shift_q ^ par_q) :
                     (PARITY == PAR_ODD)  ? ~(^shift_q ^ par_q) : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (smp_tick_i && !rxd_s) state_d = ST_START;
      ST_START: begin
        if (maj_ev && maj) state_d = ST_IDLE;
        else if (bit_end)  state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && idx_q == IDX_LAST)
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY:  if (bit_end) state_d = ST_STOP;
      ST_STOP:    if (done) state_d = maj ? ST_IDLE : ST_WAIT_HI;
      ST_WAIT_HI: if (rxd_s) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one unassigned (no latch).
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_err_d = stop_err_q;
    smp_d      = smp_q;
    data_d     = data_q;
    flag_d     = 1'b0;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    brk_d      = brk_q;

    // The detecting tick is sample 0 of the start bit, so the count leaves IDLE at 1.
    if (state_d == ST_IDLE || state_d == ST_WAIT_HI) cnt_d = '0;
    else if (smp_tick_i) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

    if (smp_tick_i && cnt_q == CNT_S0) smp_d[0] = rxd_s;
    if (smp_tick_i && cnt_q == CNT_S1) smp_d[1] = rxd_s;

    if (state_q == ST_IDLE) begin
      idx_d      = '0;
      stop_err_d = 1'b0;
    end

    if (maj_ev) begin
      if (state_q == ST_DATA)               shift_d    = {maj, shift_q[DATA_W-1:1]};
      if (state_q == ST_PARITY)             par_d      = maj;
      if (state_q == ST_STOP && !last_stop) stop_err_d = stop_err_q | ~maj;
    end

    if (bit_end) begin
      if (state_q == ST_DATA && idx_q == IDX_LAST)     idx_d = '0;
      else if (state_q == ST_DATA || state_q == ST_STOP) idx_d = idx_q + 1'b1;
    end

    if (done) begin
      data_d    = shift_q;
      flag_d    = 1'b1;
      par_err_d = par_calc;
      frm_err_d = stop_err_q | ~maj;
      brk_d     = (shift_q == '0) && (PARITY == PAR_NONE || !par_q) &&
                  !maj && (STOP_W == 1 || stop_err_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_err_q <= 1'b0;
      smp_q      <= 2'b11;
      data_q     <= '0;
      flag_q     <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop_err_q <= stop_err_d;
      smp_q      <= smp_d;
      data_q     <= data_d;
      flag_q     <= flag_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      brk_q      <= brk_d;
    end
  end

  assign rxd_data_o = data_q;
  assign rxd_flag_o = flag_q;
  assign par_err_o  = par_err_q;
  assign frm_err_o  = frm_err_q;
  assign brk_o      = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three parameter sets driven with directed and random
// serial frames, each flag compared with a frame-level reference model.
module tb_uart_rx_param;

  typedef struct packed {
    logic [8:0] data;
    logic       par;
    logic       frm;
    logic       brk;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       smp_tick;
  logic [2:0] rxd;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [2:0] flag, perr, ferr, brk;

  rec_t obs_q[3][$];
  rec_t exp_q[3][$];
  int   checks = 0;
  int   errors = 0;

  uart_rx_param #(.DATA_W(8), .OVS(16), .PARITY(0), .STOP_W(1)) u_rx0 (
    .clk(clk), .rst_n(rst_n), .smp_tick_i(smp_tick), .rxd_i(rxd[0]),
    .rxd_data_o(d0), .rxd_flag_o(flag[0]), .par_err_o(perr[0]),
    .frm_err_o(ferr[0]), .brk_o(brk[0]));

  uart_rx_param #(.DATA_W(8), .OVS(16), .PARITY(1), .STOP_W(1)) u_rx1 (
    .clk(clk), .rst_n(rst_n), .smp_tick_i(smp_tick), .rxd_i(rxd[1]),
    .rxd_data_o(d1), .rxd_flag_o(flag[1]), .par_err_o(perr[1]),
    .frm_err_o(ferr[1]), .brk_o(brk[1]));

  uart_rx_param #(.DATA_W(7), .OVS(8), .PARITY(2), .STOP_W(2)) u_rx2 (
    .clk(clk), .rst_n(rst_n), .smp_tick_i(smp_tick), .rxd_i(rxd[2]),
    .rxd_data_o(d2), .rxd_flag_o(flag[2]), .par_err_o(perr[2]),
    .frm_err_o(ferr[2]), .brk_o(brk[2]));

  always #5 clk = ~clk;

  initial begin
    smp_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 smp_tick = 1'b1;
      @(posedge clk);
      #1 smp_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (flag[0]) obs_q[0].push_back({1'b0, d0, perr[0], ferr[0], brk[0]});
    if (flag[1]) obs_q[1].push_back({1'b0, d1, perr[1], ferr[1], brk[1]});
    if (flag[2]) obs_q[2].push_back({2'b0, d2, perr[2], ferr[2], brk[2]});
  end

  function automatic int ovs_of(input int i);  return (i == 2) ? 8 : 16; endfunction
  function automatic int dw_of(input int i);   return (i == 2) ? 7 : 8;  endfunction
  function automatic int par_of(input int i);  return i;                 endfunction
  function automatic int stop_of(input int i); return (i == 2) ? 2 : 1;  endfunction

  function automatic logic good_par(input int inst, input logic [8:0] data);
    int ones;
    ones = $countones(data & ((9'd1 << dw_of(inst)) - 9'd1));
    return (par_of(inst) == 2) ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
  endfunction

  // Reference: what a receiver must report for the bits that were put on the line.
  function automatic rec_t model(input int inst, input logic [8:0] data,
                                 input logic pbit, input logic [1:0] stops);
    rec_t r;
    int   ones;
    logic all_lo;
    r.data = data & ((9'd1 << dw_of(inst)) - 9'd1);
    ones   = $countones(r.data) + int'(pbit);
    case (par_of(inst))
      1:       r.par = (ones % 2) != 0;
      2:       r.par = (ones % 2) != 1;
      default: r.par = 1'b0;
    endcase
    r.frm  = !stops[0] || (stop_of(inst) == 2 && !stops[1]);
    all_lo = !stops[0] && (stop_of(inst) == 1 || !stops[1]);
    r.brk  = (r.data == 9'd0) && (par_of(inst) == 0 || !pbit) && all_lo;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (smp_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic drive(input int inst, input logic v);
    rxd[inst] = v;
  endtask

  task automatic idle(input int inst, input int n);
    drive(inst, 1'b1);
    wait_ticks(n);
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, input int last_len, input int glitch_bit);
    int ovs;
    ovs = ovs_of(inst);
    exp_q[inst].push_back(model(inst, data, pbit, stops));
    drive(inst, 1'b0);
    wait_ticks(ovs);
    for (int b = 0; b < dw_of(inst); b++) begin
      drive(inst, data[b]);
      if (b == glitch_bit) begin
        wait_ticks(ovs / 2 - 1);
        drive(inst, ~data[b]);
        wait_ticks(1);
        drive(inst, data[b]);
        wait_ticks(ovs - ovs / 2);
      end else begin
        wait_ticks(ovs);
      end
    end
    if (par_of(inst) != 0) begin
      drive(inst, pbit);
      wait_ticks(ovs);
    end
    for (int s = 0; s < stop_of(inst); s++) begin
      drive(inst, stops[s]);
      wait_ticks((s == stop_of(inst) - 1) ? last_len : ovs);
    end
  endtask

  task automatic check_frames(input int inst);
    rec_t o, e;
    check($sformatf("flags_i%0d", inst), obs_q[inst].size(), exp_q[inst].size());
    while (obs_q[inst].size() > 0 && exp_q[inst].size() > 0) begin
      o = obs_q[inst].pop_front();
      e = exp_q[inst].pop_front();
      check($sformatf("data_i%0d", inst),    o.data, e.data);
      check($sformatf("par_err_i%0d", inst), o.par,  e.par);
      check($sformatf("frm_err_i%0d", inst), o.frm,  e.frm);
      check($sformatf("brk_i%0d", inst),     o.brk,  e.brk);
    end
    obs_q[inst].delete();
    exp_q[inst].delete();
  endtask

  initial begin
    int         inst, idle_n, shrink;
    logic [8:0] rdata;
    logic       pbit;
    logic [1:0] stops;

    rst_n = 1'b0;
    rxd   = 3'b111;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {flag, perr, ferr, brk}, 12'h000);
    check("reset_data", {d0, d1, d2}, 23'h0);

    // 8N1 reference frame
    send_frame(0, 9'h55, 1'b0, 2'b01, 16, -1);
    idle(0, 32);
    check_frames(0);

    // Four-tick low pulse is a false start
    drive(0, 1'b0);
    wait_ticks(4);
    idle(0, 40);
    check_frames(0);
    send_frame(0, 9'hA5, 1'b0, 2'b01, 16, -1);
    idle(0, 32);
    check_frames(0);

    // Even parity: wrong then right parity bit
    send_frame(1, 9'hA3, 1'b1, 2'b01, 16, -1);
    idle(1, 32);
    send_frame(1, 9'hA3, 1'b0, 2'b01, 16, -1);
    idle(1, 32);
    check_frames(1);

    // Framing error, then a long break, then a clean frame
    send_frame(0, 9'h3C, 1'b0, 2'b00, 16, -1);
    idle(0, 32);
    check_frames(0);
    exp_q[0].push_back(model(0, 9'h00, 1'b0, 2'b00));
    drive(0, 1'b0);
    wait_ticks(30 * 16);
    check_frames(0);
    idle(0, 32);
    check_frames(0);
    send_frame(0, 9'h81, 1'b0, 2'b01, 16, -1);
    idle(0, 32);
    check_frames(0);

    // Back-to-back frames, nominal stop then stop shortened by 6 ticks
    send_frame(0, 9'h00, 1'b0, 2'b01, 16, -1);
    send_frame(0, 9'hFF, 1'b0, 2'b01, 16, -1);
    idle(0, 32);
    check_frames(0);
    send_frame(0, 9'h00, 1'b0, 2'b01, 10, -1);
    send_frame(0, 9'hFF, 1'b0, 2'b01, 10, -1);
    idle(0, 32);
    check_frames(0);

    // Single-tick glitch at mid bit 3
    send_frame(0, 9'h00, 1'b0, 2'b01, 16, 3);
    idle(0, 32);
    check_frames(0);

    // 7 data bits, odd parity, two stop bits
    send_frame(2, 9'h41, good_par(2, 9'h41), 2'b11, 8, -1);
    idle(2, 16);
    check_frames(2);

    // Reset in the middle of the data bits
    drive(0, 1'b0);
    wait_ticks(16);
    drive(0, 1'b0);
    wait_ticks(16);
    drive(0, 1'b1);
    wait_ticks(24);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_ctrl", {flag, perr, ferr, brk}, 12'h000);
    check("midrst_data", {d0, d1, d2}, 23'h0);
    #1 rst_n = 1'b1;
    idle(0, 32);
    check_frames(0);
    send_frame(0, 9'h12, 1'b0, 2'b01, 16, -1);
    idle(0, 32);
    check_frames(0);

    // Random frames on all three receivers
    for (int n = 0; n < 24; n++) begin
      inst  = int'($urandom_range(0, 2));
      rdata = 9'($urandom);
      pbit  = good_par(inst, rdata) ^ ($urandom_range(0, 3) == 0);
      stops = {1'($urandom_range(0, 6) != 0), 1'($urandom_range(0, 6) != 0)};
      if (stop_of(inst) == 1) stops[1] = 1'b1;
      if (stops == 2'b11) begin
        shrink = int'($urandom_range(0, ovs_of(inst) / 2 - 2));
        idle_n = ($urandom_range(0, 1) == 0) ? 0 : ovs_of(inst) * int'($urandom_range(1, 2));
      end else begin
        shrink = 0;
        idle_n = ovs_of(inst) * int'($urandom_range(1, 2));
      end
      send_frame(inst, rdata, pbit, stops, ovs_of(inst) - shrink, -1);
      if (idle_n > 0) begin
        idle(inst, idle_n);
        check_frames(inst);
      end
    end
    idle(0, 48);
    for (int i = 0; i < 3; i++) check_frames(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
